// File: rtl/prog_sequencer.sv
// Loadable program memory and instruction sequencer with RUN/STEP issue and relative branching.
// One-cycle registered fetch; instr_valid/instr_out/pc_out are held in ISSUE until instr_ready accepts.
module prog_sequencer #(
  parameter int IW = 16,
  parameter int AW = 8,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic          wr_valid,
  input  logic [IW-1:0] instruction,
  input  logic [AW-1:0] instruction_address,
  input  logic          step_req,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [IW-1:0] instr_out,
  output logic [AW-1:0] pc_out,
  input  logic          br_take,
  input  logic [OW-1:0] br_offset,
  output logic [AW:0]   prog_len,
  output logic          done
);

  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_RUN  = 2'b10;
  localparam int         XW        = (AW > OW) ? AW : OW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_ISSUE,
    S_WAIT_STEP,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_nxt;
  logic [IW-1:0] mem [2**AW];
  logic [XW-1:0] off_ext;
  logic [AW-1:0] br_target;
  logic [AW:0]   wr_end;
  logic          run_mode;
  logic          wr_en;
  logic          len_clear;

  assign run_mode  = mode[1];
  assign off_ext   = XW'($signed(br_offset));
  assign br_target = br_take ? (pc_out + off_ext[AW-1:0]) : (pc_out + AW'(1));
  assign wr_en     = (mode == MODE_LOAD) && wr_valid;
  // A fresh LOAD session (from IDLE, no write on its first cycle) starts a new program length.
  assign len_clear = (mode == MODE_LOAD) && (state == S_IDLE) && !wr_valid;
  assign wr_end    = {1'b0, instruction_address} + (AW+1)'(1);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (!run_mode) begin
      state_nxt = (mode == MODE_LOAD) ? S_LOAD : S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          pc_nxt = '0;
          if (prog_len == '0)        state_nxt = S_DONE;
          else if (mode == MODE_RUN) state_nxt = S_FETCH;
          else                       state_nxt = S_WAIT_STEP;
        end
        S_FETCH: state_nxt = S_ISSUE;
        S_ISSUE: begin
          if (instr_ready) begin
            pc_nxt = br_target;
            // RUN/STEP switches are honoured only here, so the PC never restarts.
            if ({1'b0, br_target} >= prog_len) state_nxt = S_DONE;
            else if (mode == MODE_RUN)         state_nxt = S_FETCH;
            else                               state_nxt = S_WAIT_STEP;
          end
        end
        S_WAIT_STEP: if (step_req) state_nxt = S_FETCH;
        S_DONE:      state_nxt = S_DONE;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      prog_len  <= '0;
      instr_out <= '0;
      pc_out    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (len_clear)                      prog_len <= '0;
      else if (wr_en && wr_end > prog_len) prog_len <= wr_end;
      if (state == S_FETCH) begin
        instr_out <= mem[pc];
        pc_out    <= pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[instruction_address] <= instruction;
  end

  assign instr_valid = (state == S_ISSUE);
  assign done        = (state == S_DONE);

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: expected {pc, word} pairs are queued as stimulus is set up.
module tb_prog_sequencer;
  localparam int IW = 16;
  localparam int AW = 8;
  localparam int OW = 8;
  localparam logic [1:0] M_IDLE = 2'b00, M_LOAD = 2'b01, M_RUN = 2'b10, M_STEP = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    mode = M_IDLE;
  logic          wr_valid = 1'b0;
  logic [IW-1:0] instruction = '0;
  logic [AW-1:0] instruction_address = '0;
  logic          step_req = 1'b0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [IW-1:0] instr_out;
  logic [AW-1:0] pc_out;
  logic          br_take = 1'b0;
  logic [OW-1:0] br_offset = '0;
  logic [AW:0]   prog_len;
  logic          done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [AW+IW-1:0] exp_q[$];
  logic [AW+IW-1:0] exp_e;

  prog_sequencer #(.IW(IW), .AW(AW), .OW(OW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .wr_valid(wr_valid),
    .instruction(instruction), .instruction_address(instruction_address),
    .step_req(step_req), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .pc_out(pc_out), .br_take(br_take),
    .br_offset(br_offset), .prog_len(prog_len), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (instr_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    ok = (instr_valid === 1'b1);
  endtask

  task automatic load_clear();
    wr_valid = 1'b0;
    mode = M_IDLE;
    tick();
    mode = M_LOAD;
    tick();
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
    mode = M_LOAD;
    wr_valid = 1'b1;
    instruction_address = a;
    instruction = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic load_prog(input int n, input logic [IW-1:0] base);
    load_clear();
    for (int i = 0; i < n; i++) load_word(AW'(i), base + IW'(i));
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #3;
    vectors++;
    if ({instr_valid, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_flags: got valid/done=%b want 00", {instr_valid, done});
    end
    vectors++;
    if (prog_len !== '0) begin
      miscompares++;
      $display("FAIL reset_prog_len: got %0d want 0", prog_len);
    end
    tick();
    tick();
    vectors++;
    if ({pc_out, instr_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {pc_out, instr_out});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int last;
    last = 0;
    load_clear();
    load_word(0, 16'h3001);
    load_word(1, 16'h1000);
    load_word(2, 16'h3102);
    exp_q.push_back({8'd0, 16'h3001});
    exp_q.push_back({8'd1, 16'h1000});
    exp_q.push_back({8'd2, 16'h3102});
    mode = M_RUN;
    instr_ready = 1'b1;
    br_take = 1'b0;
    for (int n = 0; n < 3; n++) begin
      wait_valid(8, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL basic_valid: instr_valid=%b want 1", instr_valid);
      end
      exp_e = exp_q.pop_front();
      vectors++;
      if ({pc_out, instr_out} !== exp_e) begin
        miscompares++;
        $display("FAIL basic_issue: got %h want %h", {pc_out, instr_out}, exp_e);
      end
      if (n > 0) begin
        vectors++;
        if (cyc - last !== 2) begin
          miscompares++;
          $display("FAIL basic_spacing: got %0d cycles want 2", cyc - last);
        end
      end
      last = cyc;
      tick();
    end
    vectors++;
    if ({done, instr_valid, prog_len} !== {1'b1, 1'b0, 9'd3}) begin
      miscompares++;
      $display("FAIL basic_done: got done=%b valid=%b len=%0d want 1 0 3", done, instr_valid, prog_len);
    end
    mode = M_IDLE;
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_clear: got %b want 0", done);
    end
  endtask

  task automatic test_branch();
    bit ok;
    bit zero_used;
    int pcs[10] = '{0, 1, 2, 3, 3, 4, 5, 6, 7, 9};
    zero_used = 1'b0;
    load_prog(10, 16'hA000);
    foreach (pcs[i]) exp_q.push_back({AW'(pcs[i]), 16'hA000 + IW'(pcs[i])});
    mode = M_RUN;
    instr_ready = 1'b1;
    while (exp_q.size() > 0) begin
      wait_valid(8, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL branch_valid: instr_valid=%b want 1", instr_valid);
        exp_q.delete();
        break;
      end
      exp_e = exp_q.pop_front();
      vectors++;
      if ({pc_out, instr_out} !== exp_e) begin
        miscompares++;
        $display("FAIL branch_issue: got %h want %h", {pc_out, instr_out}, exp_e);
      end
      br_take = 1'b0;
      br_offset = '0;
      if (exp_e[IW +: AW] == 8'd3 && !zero_used) begin
        br_take = 1'b1;
        zero_used = 1'b1;
      end
      if (exp_e[IW +: AW] == 8'd7) begin
        br_take = 1'b1;
        br_offset = 8'd2;
      end
      tick();
      br_take = 1'b0;
    end
    vectors++;
    if ({done, instr_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL branch_done: got done/valid=%b want 10", {done, instr_valid});
    end
    mode = M_IDLE;
    tick();
  endtask

  task automatic test_stall();
    bit ok;
    load_prog(10, 16'hA000);
    mode = M_RUN;
    instr_ready = 1'b0;
    wait_valid(8, ok);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) instr_ready = 1'b1;
      vectors++;
      if ({instr_valid, pc_out, instr_out} !== {1'b1, 8'd0, 16'hA000}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got %h want %h", k, {instr_valid, pc_out, instr_out}, {1'b1, 8'd0, 16'hA000});
      end
      tick();
    end
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_accept: instr_valid=%b want 0", instr_valid);
    end
    mode = M_IDLE;
    tick();
  endtask

  task automatic test_step();
    bit ok;
    bit seen;
    load_prog(4, 16'h5000);
    exp_q.push_back({8'd0, 16'h5000});
    exp_q.push_back({8'd1, 16'h5001});
    exp_q.push_back({8'd2, 16'h5002});
    mode = M_STEP;
    instr_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= instr_valid;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL step_no_pulse: instr_valid seen=%b want 0", seen);
    end
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      wait_valid(6, ok);
      exp_e = exp_q.pop_front();
      vectors++;
      if (!ok || {pc_out, instr_out} !== exp_e) begin
        miscompares++;
        $display("FAIL step_issue%0d: got valid=%b %h want %h", p, ok, {pc_out, instr_out}, exp_e);
      end
      if (p == 2) break;
      if (p == 1) begin
        instr_ready = 1'b0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        instr_ready = 1'b1;
      end
      tick();
      if (p == 1) begin
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
          seen |= instr_valid | done;
          tick();
        end
        vectors++;
        if (seen !== 1'b0) begin
          miscompares++;
          $display("FAIL step_wait: valid/done seen=%b want 0", seen);
        end
      end
    end
    mode = M_IDLE;
    tick();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    load_prog(10, 16'hC000);
    mode = M_RUN;
    instr_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      wait_valid(8, ok);
      if (n == 5) break;
      tick();
    end
    vectors++;
    if ({instr_valid, pc_out} !== {1'b1, 8'd5}) begin
      miscompares++;
      $display("FAIL rstrun_reach: got %h want %h", {instr_valid, pc_out}, {1'b1, 8'd5});
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({instr_valid, done, prog_len, pc_out} !== '0) begin
      miscompares++;
      $display("FAIL rstrun_async: got valid=%b done=%b len=%0d pc=%0d want all 0", instr_valid, done, prog_len, pc_out);
    end
    tick();
    mode = M_IDLE;
    rst = 1'b0;
    tick();
    load_clear();
    load_word(9, 16'hC009);
    vectors++;
    if (prog_len !== 9'd10) begin
      miscompares++;
      $display("FAIL rstrun_len: got %0d want 10", prog_len);
    end
    for (int i = 0; i < 10; i++) exp_q.push_back({AW'(i), 16'hC000 + IW'(i)});
    mode = M_RUN;
    while (exp_q.size() > 0) begin
      wait_valid(8, ok);
      exp_e = exp_q.pop_front();
      vectors++;
      if (!ok || {pc_out, instr_out} !== exp_e) begin
        miscompares++;
        $display("FAIL rstrun_readback: got valid=%b %h want %h", ok, {pc_out, instr_out}, exp_e);
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL rstrun_done: got %b want 1", done);
    end
    mode = M_IDLE;
    tick();
  endtask

  task automatic test_wrap();
    bit ok;
    load_clear();
    load_word(0, 16'h7000);
    load_word(255, 16'h70FF);
    vectors++;
    if (prog_len !== 9'd256) begin
      miscompares++;
      $display("FAIL wrap_len256: got %0d want 256", prog_len);
    end
    mode = M_RUN;
    instr_ready = 1'b1;
    wait_valid(8, ok);
    br_take = 1'b1;
    br_offset = 8'hFF;
    tick();
    br_take = 1'b0;
    wait_valid(8, ok);
    vectors++;
    if (!ok || {pc_out, instr_out} !== {8'd255, 16'h70FF}) begin
      miscompares++;
      $display("FAIL wrap_back: got valid=%b %h want %h", ok, {pc_out, instr_out}, {8'd255, 16'h70FF});
    end
    instr_ready = 1'b0;
    mode = M_IDLE;
    tick();
    vectors++;
    if ({instr_valid, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL wrap_abort: got valid/done=%b want 00", {instr_valid, done});
    end
    load_clear();
    load_word(9, 16'h7009);
    mode = M_RUN;
    instr_ready = 1'b1;
    wait_valid(8, ok);
    br_take = 1'b1;
    br_offset = 8'hFF;
    tick();
    br_take = 1'b0;
    vectors++;
    if ({done, instr_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL wrap_done: got done/valid=%b want 10", {done, instr_valid});
    end
    mode = M_IDLE;
    tick();
  endtask

  task automatic test_empty_and_ignore();
    mode = M_IDLE;
    wr_valid = 1'b1;
    instruction_address = 8'd50;
    instruction = 16'hDEAD;
    tick();
    wr_valid = 1'b0;
    vectors++;
    if (prog_len !== 9'd10) begin
      miscompares++;
      $display("FAIL ignore_write: prog_len got %0d want 10", prog_len);
    end
    load_clear();
    vectors++;
    if (prog_len !== 9'd0) begin
      miscompares++;
      $display("FAIL load_clear: prog_len got %0d want 0", prog_len);
    end
    mode = M_RUN;
    tick();
    vectors++;
    if ({done, instr_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL empty_done: got done/valid=%b want 10", {done, instr_valid});
    end
    mode = M_IDLE;
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_leave: done got %b want 0", done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_stall();
    test_step();
    test_reset_mid_run();
    test_wrap();
    test_empty_and_ignore();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
